enoc_network_interface: RTL and testbench
=========================================

ENOC_NETWORK_INTERFACE -- requirements
Module: enoc_network_interface

Interface
REQ-001 Parameter LOC, default 0: node address of this interface, inserted as source and checked as destination.
REQ-002 Parameter DEST_W, default 4: width of the destination and source address fields.
REQ-003 Parameter DATA_W, default 32: width of the payload field.
REQ-004 Parameter TX_DEPTH, default 4: injection FIFO depth, power of two, at least 2.
REQ-005 Parameter RX_DEPTH, default 4: ejection FIFO depth, power of two, at least 2.
REQ-006 Derived width PKT_W = 2*DEST_W + DATA_W; packet layout is {dest, src, payload}, with dest in the MSBs.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 reset_n  in  1  reset, synchronous, active-low.
REQ-009 i_core_data  in  DATA_W  payload from the core.
REQ-010 i_core_dest  in  DEST_W  destination node from the core.
REQ-011 i_core_val  in  1  core injection request.
REQ-012 o_core_rdy  out  1  injection FIFO not full.
REQ-013 o_net_data  out  PKT_W  packet to the router core input port.
REQ-014 o_net_val  out  1  o_net_data valid.
REQ-015 i_net_en  in  1  router core input port can accept a packet.
REQ-016 i_net_data  in  PKT_W  packet from the router core output port.
REQ-017 i_net_val  in  1  i_net_data valid.
REQ-018 o_net_en  out  1  ejection FIFO not full; drives the router core-output enable.
REQ-019 o_core_rx_data  out  DATA_W  ejected payload.
REQ-020 o_core_rx_src  out  DEST_W  ejected source node.
REQ-021 o_core_rx_val  out  1  ejected packet valid.
REQ-022 i_core_rx_rdy  in  1  core accepts the ejected packet.
REQ-023 o_err  out  2  sticky error flags: bit0 = overflow, bit1 = misroute.
REQ-024 o_tx_count  out  16  injected-packet count.
REQ-025 o_rx_count  out  16  ejected-packet count.

Function
REQ-026 An injection push SHALL occur when i_core_val and o_core_rdy are both high; the pushed word is {i_core_dest, LOC[DEST_W-1:0], i_core_data}.
REQ-027 o_net_val SHALL equal "injection FIFO not empty"; a pop SHALL occur when o_net_val and i_net_en are both high.
REQ-028 o_net_data SHALL present the FIFO head and SHALL hold stable while o_net_val is high and i_net_en is low.
REQ-029 There SHALL be no bypass: a packet pushed into an empty FIFO appears on o_net_val one cycle after the push edge.
REQ-030 Simultaneous push and pop SHALL keep the occupancy unchanged and SHALL be legal at any occupancy below full.
REQ-031 When the FIFO is full, o_core_rdy SHALL be 0 even if a pop occurs the same cycle; readiness returns one cycle after the pop.
REQ-032 An ejection push SHALL occur when i_net_val and o_net_en are both high.
REQ-033 If i_net_val is high while o_net_en is low, the packet SHALL be dropped and o_err[0] SHALL be set.
REQ-034 An ejected packet whose dest field is not equal to LOC SHALL still be stored, and o_err[1] SHALL be set on the push edge.
REQ-035 o_core_rx_val SHALL equal "ejection FIFO not empty"; a pop SHALL occur when o_core_rx_val and i_core_rx_rdy are both high.
REQ-036 o_core_rx_data and o_core_rx_src SHALL present the payload and src fields of the ejection FIFO head.
REQ-037 Ejection push/pop, full and empty rules SHALL mirror REQ-029 to REQ-031, with o_net_en in place of o_core_rdy.
REQ-038 FIFO read and write pointers SHALL wrap modulo the FIFO depth.
REQ-039 Occupancy SHALL be held in a counter of width log2(depth)+1.
REQ-040 o_err bits SHALL clear only on reset.

Reset
REQ-041 On reset both FIFOs SHALL be flushed, including a reset asserted mid-transfer, and any in-flight packet SHALL be discarded.
REQ-042 Reset values SHALL be: o_net_val=0, o_core_rx_val=0, o_core_rdy=1, o_net_en=1, o_err=0, o_tx_count=0, o_rx_count=0.
REQ-043 Data outputs SHALL be 0 while the corresponding FIFO is empty after reset.

Configuration
REQ-044 With macro ENOC_NI_STATS_EN defined, o_tx_count SHALL increment on each network pop and o_rx_count on each core-side ejection pop.
REQ-045 With ENOC_NI_STATS_EN defined, both counters SHALL saturate at 16'hFFFF.
REQ-046 Without ENOC_NI_STATS_EN, o_tx_count and o_rx_count SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-047 LOC=5: push dest=3, data=32'hA5A5_0001 with i_net_en=1 -> o_net_val high on the next cycle with o_net_data={4'h3,4'h5,32'hA5A5_0001}, popped that same cycle.
REQ-048 i_net_en=0, push 4 packets -> o_core_rdy=0 after the 4th push; then i_net_en=1 -> packets leave in order over 4 cycles and o_core_rdy returns.
REQ-049 i_core_rx_rdy=0, 4 packets ejected -> o_net_en=0; a 5th i_net_val -> o_err=2'b01 and the packet is dropped; then release -> 4 payloads delivered in order.
REQ-050 LOC=5, eject a packet with dest=6 -> o_err[1]=1 and the packet is still delivered with o_core_rx_src equal to the sent src.
REQ-051 Continuous push and pop at occupancy 2 for 20 cycles -> occupancy stays 2 with no loss or reordering across pointer wrap.
REQ-052 Reset asserted with 3 packets queued -> the next cycle shows o_net_val=0 and o_err=0; with ENOC_NI_STATS_EN defined the counts are 0.

Source files
------------

// File: rtl/enoc_network_interface.sv
// Network interface between a core and an eNoC router port: injection FIFO stamps {dest, LOC, payload}; ejection FIFO returns {src, payload}.
// Optional packet counters are built only when ENOC_NI_STATS_EN is defined.

module enoc_ni_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // NOTE: storage has no reset; only pointers and count do, and an empty FIFO's stale head is masked downstream.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];
endmodule

module enoc_network_interface #(
    parameter int LOC      = 0,
    parameter int DEST_W   = 4,
    parameter int DATA_W   = 32,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_W-1:0]            i_core_data,
    input  logic [DEST_W-1:0]            i_core_dest,
    input  logic                         i_core_val,
    output logic                         o_core_rdy,
    output logic [2*DEST_W+DATA_W-1:0]   o_net_data,
    output logic                         o_net_val,
    input  logic                         i_net_en,
    input  logic [2*DEST_W+DATA_W-1:0]   i_net_data,
    input  logic                         i_net_val,
    output logic                         o_net_en,
    output logic [DATA_W-1:0]            o_core_rx_data,
    output logic [DEST_W-1:0]            o_core_rx_src,
    output logic                         o_core_rx_val,
    input  logic                         i_core_rx_rdy,
    output logic [1:0]                   o_err,
    output logic [15:0]                  o_tx_count,
    output logic [15:0]                  o_rx_count
);
    localparam int PKT_W  = 2*DEST_W + DATA_W;
    localparam int RX_W   = DEST_W + DATA_W;
    localparam logic [DEST_W-1:0] LOC_ADDR = DEST_W'(LOC);

    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [PKT_W-1:0] tx_head;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [RX_W-1:0]  rx_head;
    logic [DEST_W-1:0] rx_dest;

    // Injection path
    assign tx_push = i_core_val && !tx_full;
    assign tx_pop  = !tx_empty && i_net_en;

    enoc_ni_fifo #(.WIDTH(PKT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .wdata   ({i_core_dest, LOC_ADDR, i_core_data}),
        .pop     (tx_pop),
        .rdata   (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign o_core_rdy = !tx_full;
    assign o_net_val  = !tx_empty;
    assign o_net_data = tx_empty ? '0 : tx_head;

    // Ejection path: the dest field is only needed for the misroute check, so only {src, payload} is stored.
    assign rx_dest = i_net_data[PKT_W-1 -: DEST_W];
    assign rx_push = i_net_val && !rx_full;
    assign rx_pop  = !rx_empty && i_core_rx_rdy;

    enoc_ni_fifo #(.WIDTH(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .wdata   (i_net_data[RX_W-1:0]),
        .pop     (rx_pop),
        .rdata   (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign o_net_en       = !rx_full;
    assign o_core_rx_val  = !rx_empty;
    assign o_core_rx_data = rx_empty ? '0 : rx_head[DATA_W-1:0];
    assign o_core_rx_src  = rx_empty ? '0 : rx_head[RX_W-1 -: DEST_W];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_err <= 2'b00;
        end else begin
            if (i_net_val && rx_full)             o_err[0] <= 1'b1;
            if (rx_push && (rx_dest != LOC_ADDR)) o_err[1] <= 1'b1;
        end
    end

`ifdef ENOC_NI_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_tx_count <= 16'd0;
            o_rx_count <= 16'd0;
        end else begin
            if (tx_pop && (o_tx_count != 16'hFFFF)) o_tx_count <= o_tx_count + 16'd1;
            if (rx_pop && (o_rx_count != 16'hFFFF)) o_rx_count <= o_rx_count + 16'd1;
        end
    end
`else
    assign o_tx_count = 16'd0;
    assign o_rx_count = 16'd0;
`endif
endmodule

// File: tb/tb_enoc_network_interface.sv
// Bench for enoc_network_interface (LOC=5): injection vector table, scoreboard monitors on both FIFOs,
// and directed sequences for overflow, misroute, pointer wrap and mid-transfer reset.
module tb_enoc_network_interface;
    localparam int LOC    = 5;
    localparam int DEST_W = 4;
    localparam int DATA_W = 32;
    localparam int PKT_W  = 2*DEST_W + DATA_W;
    localparam int RX_W   = DEST_W + DATA_W;

    logic              clk;
    logic              reset_n;
    logic [DATA_W-1:0] i_core_data;
    logic [DEST_W-1:0] i_core_dest;
    logic              i_core_val;
    logic              o_core_rdy;
    logic [PKT_W-1:0]  o_net_data;
    logic              o_net_val;
    logic              i_net_en;
    logic [PKT_W-1:0]  i_net_data;
    logic              i_net_val;
    logic              o_net_en;
    logic [DATA_W-1:0] o_core_rx_data;
    logic [DEST_W-1:0] o_core_rx_src;
    logic              o_core_rx_val;
    logic              i_core_rx_rdy;
    logic [1:0]        o_err;
    logic [15:0]       o_tx_count;
    logic [15:0]       o_rx_count;

    enoc_network_interface #(
        .LOC(LOC), .DEST_W(DEST_W), .DATA_W(DATA_W), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_core_data    (i_core_data),
        .i_core_dest    (i_core_dest),
        .i_core_val     (i_core_val),
        .o_core_rdy     (o_core_rdy),
        .o_net_data     (o_net_data),
        .o_net_val      (o_net_val),
        .i_net_en       (i_net_en),
        .i_net_data     (i_net_data),
        .i_net_val      (i_net_val),
        .o_net_en       (o_net_en),
        .o_core_rx_data (o_core_rx_data),
        .o_core_rx_src  (o_core_rx_src),
        .o_core_rx_val  (o_core_rx_val),
        .i_core_rx_rdy  (i_core_rx_rdy),
        .o_err          (o_err),
        .o_tx_count     (o_tx_count),
        .o_rx_count     (o_rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_tx_cnt = 0;
    int exp_rx_cnt = 0;
    logic [PKT_W-1:0] tx_q[$];
    logic [RX_W-1:0]  rx_q[$];

    typedef struct {
        logic              val;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
        logic              net_en;
        logic              exp_rdy;
        logic              exp_nval;
    } tx_vec_t;

    tx_vec_t tv[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the head must match the oldest expected packet every valid cycle; a handshake retires it.
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_net_val) begin
                if (tx_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL tx_unexpected: got %h expected none", o_net_data);
                end else begin
                    check("tx_head", 64'(o_net_data), 64'(tx_q[0]));
                    if (i_net_en) begin
                        void'(tx_q.pop_front());
`ifdef ENOC_NI_STATS_EN
                        exp_tx_cnt++;
`endif
                    end
                end
            end
            if (o_core_rx_val) begin
                if (rx_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rx_unexpected: got %h expected none", {o_core_rx_src, o_core_rx_data});
                end else begin
                    check("rx_head", 64'({o_core_rx_src, o_core_rx_data}), 64'(rx_q[0]));
                    if (i_core_rx_rdy) begin
                        void'(rx_q.pop_front());
`ifdef ENOC_NI_STATS_EN
                        exp_rx_cnt++;
`endif
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // val, dest, data, net_en, expected o_core_rdy, expected o_net_val (sampled before the edge)
        tv[0]  = '{1'b1, 4'h3, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0};
        tv[1]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        tv[2]  = '{1'b1, 4'h1, 32'h0000_0011, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 4'h2, 32'h0000_0022, 1'b0, 1'b1, 1'b1};
        tv[4]  = '{1'b1, 4'h3, 32'h0000_0033, 1'b0, 1'b1, 1'b1};
        tv[5]  = '{1'b1, 4'h4, 32'h0000_0044, 1'b0, 1'b1, 1'b1};
        tv[6]  = '{1'b1, 4'h5, 32'h0000_0055, 1'b0, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 4'h6, 32'h0000_0066, 1'b1, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        tv[9]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        tv[10] = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        tv[11] = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0; i_core_data = '0; i_core_dest = '0; i_core_val = 1'b0;
        i_net_en = 1'b0; i_net_data = '0; i_net_val = 1'b0; i_core_rx_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_net_val",  64'(o_net_val), 64'd0);
        check("rst_rx_val",   64'(o_core_rx_val), 64'd0);
        check("rst_core_rdy", 64'(o_core_rdy), 64'd1);
        check("rst_net_en",   64'(o_net_en), 64'd1);
        check("rst_err",      64'(o_err), 64'd0);
        check("rst_tx_cnt",   64'(o_tx_count), 64'd0);
        check("rst_rx_cnt",   64'(o_rx_count), 64'd0);
        check("rst_net_data", 64'(o_net_data), 64'd0);
        check("rst_rx_data",  64'({o_core_rx_src, o_core_rx_data}), 64'd0);
        next_cycle();
        reset_n = 1'b1;

        // Injection table: single-packet latency, fill to full, full-with-pop, drain in order.
        for (int i = 0; i < 12; i++) begin
            i_core_val  = tv[i].val;
            i_core_dest = tv[i].dest;
            i_core_data = tv[i].data;
            i_net_en    = tv[i].net_en;
            if (tv[i].val && tv[i].exp_rdy) tx_q.push_back({tv[i].dest, 4'(LOC), tv[i].data});
            @(negedge clk);
            check($sformatf("tx_vec%0d_rdy", i),  64'(o_core_rdy), 64'(tv[i].exp_rdy));
            check($sformatf("tx_vec%0d_nval", i), 64'(o_net_val),  64'(tv[i].exp_nval));
            next_cycle();
        end

        // Steady push+pop at occupancy 2 across pointer wrap.
        i_net_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_core_val = 1'b1; i_core_dest = 4'(i + 8); i_core_data = 32'hF000_0000 + 32'(i);
            tx_q.push_back({i_core_dest, 4'(LOC), i_core_data});
            next_cycle();
        end
        for (int i = 0; i < 20; i++) begin
            i_core_val = 1'b1; i_net_en = 1'b1;
            i_core_dest = 4'(i); i_core_data = 32'hC000_0000 + 32'(i);
            tx_q.push_back({i_core_dest, 4'(LOC), i_core_data});
            @(negedge clk);
            check($sformatf("wrap%0d_rdy", i),  64'(o_core_rdy), 64'd1);
            check($sformatf("wrap%0d_nval", i), 64'(o_net_val),  64'd1);
            next_cycle();
        end
        i_core_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("wrap_drain%0d_nval", i), 64'(o_net_val), (i < 2) ? 64'd1 : 64'd0);
            next_cycle();
        end
        check("tx_all_delivered", 64'(tx_q.size()), 64'd0);
        check("tx_count", 64'(o_tx_count), 64'(exp_tx_cnt));

        // Ejection overflow: 4 accepted, 5th dropped and flagged.
        i_core_rx_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_net_val  = 1'b1;
            i_net_data = {4'(LOC), 4'(i + 1), 32'hB000_0000 + 32'(i)};
            if (i < 4) rx_q.push_back(i_net_data[RX_W-1:0]);
            @(negedge clk);
            check($sformatf("rx_fill%0d_net_en", i), 64'(o_net_en), (i < 4) ? 64'd1 : 64'd0);
            next_cycle();
        end
        i_net_val = 1'b0;
        @(negedge clk);
        check("overflow_err", 64'(o_err), 64'b01);
        check("overflow_rx_val", 64'(o_core_rx_val), 64'd1);
        next_cycle();
        i_core_rx_rdy = 1'b1;
        repeat (6) next_cycle();
        @(negedge clk);
        check("rx_all_delivered", 64'(rx_q.size()), 64'd0);
        check("rx_idle_val", 64'(o_core_rx_val), 64'd0);
        check("rx_idle_net_en", 64'(o_net_en), 64'd1);
        check("rx_count", 64'(o_rx_count), 64'(exp_rx_cnt));
        check("err_sticky", 64'(o_err), 64'b01);
        next_cycle();

        // Reset with 3 packets queued: everything flushed.
        i_net_en = 1'b0; i_core_rx_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_core_val = 1'b1; i_core_dest = 4'h7; i_core_data = 32'hDD00_0000 + 32'(i);
            tx_q.push_back({i_core_dest, 4'(LOC), i_core_data});
            next_cycle();
        end
        i_core_val = 1'b0;
        @(negedge clk);
        check("prereset_nval", 64'(o_net_val), 64'd1);
        next_cycle();
        reset_n = 1'b0;
        tx_q.delete(); rx_q.delete();
        exp_tx_cnt = 0; exp_rx_cnt = 0;
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_nval",     64'(o_net_val), 64'd0);
        check("midrst_err",      64'(o_err), 64'd0);
        check("midrst_rdy",      64'(o_core_rdy), 64'd1);
        check("midrst_net_data", 64'(o_net_data), 64'd0);
        check("midrst_tx_cnt",   64'(o_tx_count), 64'd0);
        check("midrst_rx_cnt",   64'(o_rx_count), 64'd0);
        next_cycle();

        // Misroute: dest 6 at LOC 5 is stored, delivered, and flagged.
        i_net_val  = 1'b1;
        i_net_data = {4'h6, 4'h9, 32'hDEAD_0050};
        rx_q.push_back({4'h9, 32'hDEAD_0050});
        next_cycle();
        i_net_val = 1'b0;
        @(negedge clk);
        check("misroute_err", 64'(o_err), 64'b10);
        check("misroute_rx_val", 64'(o_core_rx_val), 64'd1);
        next_cycle();
        i_core_rx_rdy = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        check("misroute_delivered", 64'(rx_q.size()), 64'd0);
        check("misroute_err_sticky", 64'(o_err), 64'b10);
        check("misroute_rx_count", 64'(o_rx_count), 64'(exp_rx_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
